jedro_1_ifu: RTL and testbench
==============================

Name: jedro_1_ifu

Overview:
Instruction fetch unit for riscv-jedro-1. It sits directly upstream of jedro_1_decoder and owns the fetch PC. It issues word requests to instruction memory over a req/gnt/rvalid handshake and buffers returned words in a small prefetch FIFO. It presents each word with its PC to the decoder, and flushes and redirects on jumps or taken branches.

Parameters:
BOOT_ADDR, 32'h0000_0000, PC after reset; bits [1:0] must be 0.
FIFO_DEPTH, 2, prefetch buffer entries (power of two, >=2).

Ports:
clk_i  input  1  clock; all state on rising edge.
rstn_i  input  1  asynchronous active-low reset.
imem_req_o  output  1  fetch request valid.
imem_addr_o  output  `DATA_WIDTH  fetch word address; [1:0] always 0.
imem_gnt_i  input  1  memory accepted request this cycle.
imem_rvalid_i  input  1  read data valid for oldest accepted request.
imem_rdata_i  input  `DATA_WIDTH  instruction word.
jmp_i  input  1  redirect request from execute (jump or taken branch).
jmp_addr_i  input  `DATA_WIDTH  redirect target; bits [1:0] ignored (forced 0).
dec_ready_i  input  1  decoder consumes head instruction this cycle.
dec_valid_o  output  1  head instruction valid.
dec_instr_o  output  `DATA_WIDTH  instruction to decoder (drives instr_rdata_i).
dec_pc_o  output  `DATA_WIDTH  PC of dec_instr_o.

Behaviour:
- Reset (rstn_i low, asynchronous):
  - State S_REQ; fetch_pc = BOOT_ADDR; FIFO empty; discard flag = 0.
  - imem_req_o = 0 while reset is asserted; it first rises in the first cycle after deassertion.
  - dec_valid_o = 0; dec_instr_o = 32'h0000_0013 (NOP); dec_pc_o = BOOT_ADDR.
- Reset mid-transaction: all state is dropped immediately. Any late rvalid after reset is not pushed, because the FSM is not in S_WAIT.
- At most one outstanding memory transaction.
- FSM:
  - S_REQ: imem_req_o = 1 iff FIFO free slots >= 1 after this cycle's pop, with imem_addr_o = fetch_pc. On gnt, go to S_WAIT and fetch_pc += 4 (32-bit wrap at 0xFFFF_FFFC -> 0).
  - S_WAIT: imem_req_o = 0. On rvalid: push {rdata, pc} unless discard = 1; clear discard; go to S_REQ.
- OBI stability: once imem_req_o is high with gnt low, imem_addr_o and imem_req_o are held until gnt, even if jmp_i arrives.
- Redirect (jmp_i = 1):
  - FIFO flushed at the clock edge; dec_valid_o = 0 the next cycle.
  - fetch_pc = {jmp_addr_i[31:2], 2'b00}.
  - If a transaction is in flight (S_WAIT, or S_REQ with req high), set discard = 1 and drop the returning word.
  - With jmp_i and gnt in the same cycle, the granted request is discarded; fetch_pc is still the jump target, not +4.
  - With jmp_i and rvalid in the same cycle, the word is dropped.
  - The next request after a redirect is always the target.
- Decoder side:
  - dec_valid_o = !empty; dec_instr_o and dec_pc_o = FIFO head.
  - Pop when dec_valid_o && dec_ready_i && !jmp_i.
  - When empty, outputs hold their last value (NOP after reset).
- FIFO:
  - No combinational bypass: rvalid -> dec_valid_o latency is 1 cycle.
  - Request gating guarantees no push when full.
  - Push and pop in the same cycle keep the count unchanged.
- Best-case throughput: 1 instruction per 2 cycles (single outstanding). Steady state with gnt tied high and 1-cycle rvalid: alternating REQ/WAIT.

Decomposition:
- Add to jedro_1_defines.v: `NOP_INSTR (32'h0000_0013), IFU state encodings (`IFU_S_REQ, `IFU_S_WAIT). Reuse `DATA_WIDTH.
- One sub-module, jedro_1_fifo: parameters DATA_WIDTH and DEPTH; push, pop, flush, full, empty, count; async active-low reset. The IFU instantiates it with width 2*`DATA_WIDTH for {pc, instr}.

Test Plan:
- Reset release, memory gnt=1, rvalid next cycle with words 0x00500093, 0x00A00113 -> addresses 0x0, 0x4 requested; dec_valid_o with dec_pc_o 0x0 then 0x4, instructions in order.
- dec_ready_i=0 for 10 cycles -> exactly FIFO_DEPTH (2) words buffered; imem_req_o stays 0 until a pop frees a slot; no word lost or duplicated.
- gnt held low 3 cycles with jmp_i=1 (target 0x100) on cycle 1 -> imem_addr_o stays 0x8 until gnt; that response is dropped; next request is addr 0x100; first dec_pc_o after redirect is 0x100.
- jmp_i with jmp_addr_i=0x203 coincident with rvalid -> word dropped, FIFO empty next cycle, next request addr 0x200.
- BOOT_ADDR=32'hFFFF_FFFC -> first fetch 0xFFFF_FFFC, second fetch 0x0000_0000 (wrap).
- rstn_i asserted while in S_WAIT, rvalid arrives during reset -> outputs at reset values immediately; after release, first request is BOOT_ADDR and nothing stale is pushed.

Source files
------------

// File: rtl/jedro_1_pkg.sv
// Shared constants and types for the jedro_1 instruction fetch path.
package jedro_1_pkg;

    localparam int DATA_WIDTH = 32;
    localparam logic [DATA_WIDTH-1:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic {
        IFU_S_REQ  = 1'b0,
        IFU_S_WAIT = 1'b1
    } ifu_state_e;

    function automatic logic [DATA_WIDTH-1:0] word_align(input logic [DATA_WIDTH-1:0] addr);
        return addr & ~32'h0000_0003;
    endfunction

endpackage

// File: rtl/jedro_1_fifo.sv
// Small synchronous FIFO with flush; head entry is visible on data_o while not empty.
module jedro_1_fifo #(
    parameter int DATA_WIDTH = 64,
    parameter int DEPTH      = 2
) (
    input  logic                         clk_i,
    input  logic                         rstn_i,
    input  logic                         push_i,
    input  logic [DATA_WIDTH-1:0]        data_i,
    input  logic                         pop_i,
    input  logic                         flush_i,
    output logic [DATA_WIDTH-1:0]        data_o,
    output logic                         full_o,
    output logic                         empty_o,
    output logic [$clog2(DEPTH):0]       count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]         wptr_q;
    logic [AW-1:0]         rptr_q;
    logic [CW-1:0]         count_q;

    assign data_o  = mem_q[rptr_q];
    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else if (flush_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (push_i) begin
                mem_q[wptr_q] <= data_i;
                wptr_q        <= wptr_q + AW'(1);
            end
            if (pop_i) begin
                rptr_q <= rptr_q + AW'(1);
            end
            count_q <= count_q + CW'(push_i) - CW'(pop_i);
        end
    end

endmodule

// File: rtl/jedro_1_ifu.sv
// Instruction fetch unit: single-outstanding word fetch into a prefetch FIFO feeding the decoder.
module jedro_1_ifu
    import jedro_1_pkg::*;
#(
    parameter logic [31:0] BOOT_ADDR  = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic                  clk_i,
    input  logic                  rstn_i,
    output logic                  imem_req_o,
    output logic [DATA_WIDTH-1:0] imem_addr_o,
    input  logic                  imem_gnt_i,
    input  logic                  imem_rvalid_i,
    input  logic [DATA_WIDTH-1:0] imem_rdata_i,
    input  logic                  jmp_i,
    input  logic [DATA_WIDTH-1:0] jmp_addr_i,
    input  logic                  dec_ready_i,
    output logic                  dec_valid_o,
    output logic [DATA_WIDTH-1:0] dec_instr_o,
    output logic [DATA_WIDTH-1:0] dec_pc_o
);

    localparam int FW = 2 * DATA_WIDTH;
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    ifu_state_e            state_q;
    logic [DATA_WIDTH-1:0] fetch_pc_q;
    logic [DATA_WIDTH-1:0] held_addr_q;
    logic                  pending_q;
    logic                  discard_q;
    logic [DATA_WIDTH-1:0] last_instr_q;
    logic [DATA_WIDTH-1:0] last_pc_q;

    logic [FW-1:0]         fifo_head;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [CW-1:0]         fifo_count;
    logic                  fifo_push;
    logic                  fifo_pop;
    logic                  slot_free;
    logic [DATA_WIDTH-1:0] jmp_target;

    assign jmp_target = word_align(jmp_addr_i);
    assign fifo_pop   = !fifo_empty && dec_ready_i && !jmp_i;
    assign slot_free  = (fifo_count < CW'(FIFO_DEPTH)) || fifo_pop;

    // A request left ungranted is frozen (address and valid) until the memory takes it.
    assign imem_req_o  = rstn_i && (state_q == IFU_S_REQ) && (pending_q || slot_free);
    assign imem_addr_o = pending_q ? held_addr_q : fetch_pc_q;

    assign fifo_push = (state_q == IFU_S_WAIT) && imem_rvalid_i && !discard_q && !jmp_i && !fifo_full;

    assign dec_valid_o = !fifo_empty;
    assign dec_instr_o = fifo_empty ? last_instr_q : fifo_head[DATA_WIDTH-1:0];
    assign dec_pc_o    = fifo_empty ? last_pc_q : fifo_head[FW-1:DATA_WIDTH];

    jedro_1_fifo #(
        .DATA_WIDTH (FW),
        .DEPTH      (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rstn_i  (rstn_i),
        .push_i  (fifo_push),
        .data_i  ({fetch_pc_q - 32'd4, imem_rdata_i}),
        .pop_i   (fifo_pop),
        .flush_i (jmp_i),
        .data_o  (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q      <= IFU_S_REQ;
            fetch_pc_q   <= BOOT_ADDR;
            held_addr_q  <= BOOT_ADDR;
            pending_q    <= 1'b0;
            discard_q    <= 1'b0;
            last_instr_q <= NOP_INSTR;
            last_pc_q    <= BOOT_ADDR;
        end else begin
            if (!fifo_empty) begin
                last_instr_q <= fifo_head[DATA_WIDTH-1:0];
                last_pc_q    <= fifo_head[FW-1:DATA_WIDTH];
            end
            case (state_q)
                IFU_S_REQ: begin
                    if (imem_req_o) begin
                        if (imem_gnt_i) begin
                            state_q   <= IFU_S_WAIT;
                            pending_q <= 1'b0;
                            // A held request granted after a redirect must not advance the target PC.
                            if (!jmp_i && !discard_q) begin
                                fetch_pc_q <= fetch_pc_q + 32'd4;
                            end
                        end else begin
                            pending_q   <= 1'b1;
                            held_addr_q <= imem_addr_o;
                        end
                        if (jmp_i) begin
                            discard_q <= 1'b1;
                        end
                    end
                end
                IFU_S_WAIT: begin
                    if (imem_rvalid_i) begin
                        state_q   <= IFU_S_REQ;
                        discard_q <= 1'b0;
                    end else if (jmp_i) begin
                        discard_q <= 1'b1;
                    end
                end
                default: state_q <= IFU_S_REQ;
            endcase
            if (jmp_i) begin
                fetch_pc_q <= jmp_target;
            end
        end
    end

    a_req_stable: assert property (@(posedge clk_i) disable iff (!rstn_i)
        imem_req_o && !imem_gnt_i |=> imem_req_o && $stable(imem_addr_o));
    a_addr_aligned: assert property (@(posedge clk_i) disable iff (!rstn_i)
        imem_req_o |-> imem_addr_o[1:0] == 2'b00);
    a_no_push_full: assert property (@(posedge clk_i) disable iff (!rstn_i)
        !(fifo_push && fifo_full && !fifo_pop));

endmodule

// File: tb/tb_jedro_1_ifu.sv
// Bench for jedro_1_ifu: transaction-level model of expected fetches and decoder stream, plus directed scenarios.
module tb_jedro_1_ifu;

    localparam logic [31:0] BOOT  = 32'h0000_0000;
    localparam logic [31:0] BOOT2 = 32'hFFFF_FFFC;
    localparam int          DEPTH = 2;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        imem_gnt_i = 1'b0;
    logic        imem_rvalid_i = 1'b0;
    logic [31:0] imem_rdata_i = '0;
    logic        jmp_i = 1'b0;
    logic [31:0] jmp_addr_i = '0;
    logic        dec_ready_i = 1'b0;

    logic        imem_req, dec_valid;
    logic [31:0] imem_addr, dec_instr, dec_pc;
    logic        b_req, b_valid;
    logic [31:0] b_addr, b_instr, b_pc;

    int n_cmp = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    jedro_1_ifu #(.BOOT_ADDR(BOOT), .FIFO_DEPTH(DEPTH)) dut (
        .clk_i(clk), .rstn_i(rstn),
        .imem_req_o(imem_req), .imem_addr_o(imem_addr), .imem_gnt_i(imem_gnt_i),
        .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i),
        .jmp_i(jmp_i), .jmp_addr_i(jmp_addr_i),
        .dec_ready_i(dec_ready_i), .dec_valid_o(dec_valid),
        .dec_instr_o(dec_instr), .dec_pc_o(dec_pc)
    );

    // Second instance only used to observe the address wrap from the top word.
    jedro_1_ifu #(.BOOT_ADDR(BOOT2), .FIFO_DEPTH(DEPTH)) dut_wrap (
        .clk_i(clk), .rstn_i(rstn),
        .imem_req_o(b_req), .imem_addr_o(b_addr), .imem_gnt_i(imem_gnt_i),
        .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i),
        .jmp_i(jmp_i), .jmp_addr_i(jmp_addr_i),
        .dec_ready_i(dec_ready_i), .dec_valid_o(b_valid),
        .dec_instr_o(b_instr), .dec_pc_o(b_pc)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h0000_0000: return 32'h0050_0093;
            32'h0000_0004: return 32'h00A0_0113;
            default:       return a ^ 32'h5A5A_0013;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- memory responder ----------------
    logic        mem_auto = 1'b1;
    logic        man_rvalid = 1'b0;
    logic [31:0] man_rdata = '0;
    int          rdelay = 0;
    logic        mem_busy = 1'b0;
    logic [31:0] mem_addr = '0;
    int          mem_cnt = 0;

    always @(posedge clk) begin
        if (!rstn) begin
            mem_busy = 1'b0;
        end else begin
            if (imem_rvalid_i && mem_busy) mem_busy = 1'b0;
            if (imem_req && imem_gnt_i) begin
                mem_busy = 1'b1;
                mem_addr = imem_addr;
                mem_cnt  = rdelay;
            end
        end
        #1;
        if (mem_auto) begin
            if (mem_busy && mem_cnt == 0) begin
                imem_rvalid_i = 1'b1;
                imem_rdata_i  = mem_word(mem_addr);
            end else begin
                imem_rvalid_i = 1'b0;
                if (mem_busy) mem_cnt--;
            end
        end else begin
            imem_rvalid_i = man_rvalid;
            imem_rdata_i  = man_rdata;
        end
    end

    // ---------------- scoreboard / model ----------------
    logic [63:0] exp_q[$];
    logic [31:0] m_exp_pc, m_last_instr, m_last_pc, m_busy_pc, m_pend_addr;
    logic        m_busy, m_busy_drop, m_pend, m_pend_drop;
    logic [31:0] grants[$];
    logic [31:0] b_grants[$];
    logic [31:0] got_pc[$];
    logic [31:0] got_instr[$];

    always @(negedge clk) begin
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_pop;
        logic [63:0] hd;
        if (!rstn) begin
            chk("rst_req", {31'b0, imem_req}, 32'd0);
            chk("rst_valid", {31'b0, dec_valid}, 32'd0);
            chk("rst_instr", dec_instr, NOP);
            chk("rst_pc", dec_pc, BOOT);
            exp_q.delete();
            m_exp_pc = BOOT; m_last_instr = NOP; m_last_pc = BOOT;
            m_busy = 0; m_busy_drop = 0; m_pend = 0; m_pend_drop = 0;
            m_busy_pc = '0; m_pend_addr = '0;
        end else begin
            e_pop = (exp_q.size() > 0) && dec_ready_i && !jmp_i;
            if (m_busy)      e_req = 1'b0;
            else if (m_pend) e_req = 1'b1;
            else             e_req = (exp_q.size() < DEPTH) || e_pop;
            e_addr = m_pend ? m_pend_addr : m_exp_pc;
            chk("req", {31'b0, imem_req}, {31'b0, e_req});
            if (e_req) chk("addr", imem_addr, e_addr);
            chk("valid", {31'b0, dec_valid}, {31'b0, exp_q.size() > 0});
            if (exp_q.size() > 0) begin
                hd = exp_q[0];
                chk("instr", dec_instr, hd[31:0]);
                chk("pc", dec_pc, hd[63:32]);
                m_last_instr = hd[31:0];
                m_last_pc    = hd[63:32];
            end else begin
                chk("hold_instr", dec_instr, m_last_instr);
                chk("hold_pc", dec_pc, m_last_pc);
            end
            if (imem_req && imem_gnt_i) grants.push_back(imem_addr);
            if (b_req && imem_gnt_i) b_grants.push_back(b_addr);
            if (dec_valid && dec_ready_i && !jmp_i) begin
                got_pc.push_back(dec_pc);
                got_instr.push_back(dec_instr);
            end
            // advance the model across the coming edge
            if (e_pop) void'(exp_q.pop_front());
            if (imem_rvalid_i && m_busy) begin
                if (!m_busy_drop && !jmp_i) exp_q.push_back({m_busy_pc, imem_rdata_i});
                m_busy = 1'b0;
            end
            if (e_req && imem_gnt_i) begin
                m_busy      = 1'b1;
                m_busy_pc   = e_addr;
                m_busy_drop = m_pend && m_pend_drop;
                if (!m_busy_drop) m_exp_pc = m_exp_pc + 32'd4;
                m_pend = 1'b0;
            end else if (e_req && !m_pend) begin
                m_pend      = 1'b1;
                m_pend_addr = e_addr;
                m_pend_drop = 1'b0;
            end
            if (jmp_i) begin
                exp_q.delete();
                m_exp_pc = jmp_addr_i & ~32'h3;
                if (m_busy) m_busy_drop = 1'b1;
                if (m_pend) m_pend_drop = 1'b1;
            end
        end
    end

    // ---------------- driver ----------------
    task automatic step(input int n = 1);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        rstn = 1'b0; jmp_i = 1'b0; jmp_addr_i = '0; imem_gnt_i = 1'b1;
        dec_ready_i = 1'b1; mem_auto = 1'b1; rdelay = 0;
        step(2);
        grants.delete(); b_grants.delete(); got_pc.delete(); got_instr.delete();
        rstn = 1'b1;
    endtask

    task automatic wait_grants(input int n);
        int t = 0;
        while (grants.size() < n && t < 40) begin
            step();
            t++;
        end
        if (grants.size() < n) begin
            n_cmp++; n_fail++;
            $display("FAIL wait_grants: got %0d grants expected %0d", grants.size(), n);
        end
    endtask

    initial begin
        int mark;
        // Reset release and first two fetches, plus top-of-memory wrap on the second instance
        do_reset();
        wait_grants(2);
        step(6);
        chk("t1_grant0", grants[0], 32'h0000_0000);
        chk("t1_grant1", grants[1], 32'h0000_0004);
        chk("t1_pc0", got_pc[0], 32'h0000_0000);
        chk("t1_instr0", got_instr[0], 32'h0050_0093);
        chk("t1_pc1", got_pc[1], 32'h0000_0004);
        chk("t1_instr1", got_instr[1], 32'h00A0_0113);
        chk("wrap_grant0", b_grants[0], 32'hFFFF_FFFC);
        chk("wrap_grant1", b_grants[1], 32'h0000_0000);

        // Decoder stall fills the buffer and gates requests
        dec_ready_i = 1'b0;
        step(10);
        chk("t2_req_gated", {31'b0, imem_req}, 32'd0);
        chk("t2_valid", {31'b0, dec_valid}, 32'd1);
        chk("t2_buffered", exp_q.size(), DEPTH);
        dec_ready_i = 1'b1;
        step(12);
        for (int i = 1; i < got_pc.size(); i++) begin
            chk("t2_seq_pc", got_pc[i], got_pc[i-1] + 32'd4);
            chk("t2_seq_instr", got_instr[i], mem_word(got_pc[i]));
        end

        // Redirect while a request waits for grant
        do_reset();
        wait_grants(2);
        imem_gnt_i = 1'b0;
        step();
        jmp_i = 1'b1; jmp_addr_i = 32'h0000_0100;
        mark = got_pc.size();
        #1;
        chk("t3_hold_addr_a", imem_addr, 32'h0000_0008);
        chk("t3_hold_req_a", {31'b0, imem_req}, 32'd1);
        step();
        jmp_i = 1'b0;
        #1;
        chk("t3_hold_addr_b", imem_addr, 32'h0000_0008);
        step();
        chk("t3_hold_addr_c", imem_addr, 32'h0000_0008);
        imem_gnt_i = 1'b1;
        step(12);
        chk("t3_grant2", grants[2], 32'h0000_0008);
        chk("t3_grant3", grants[3], 32'h0000_0100);
        chk("t3_first_pc", got_pc[mark], 32'h0000_0100);

        // Redirect coincident with read data
        do_reset();
        wait_grants(3);
        jmp_i = 1'b1; jmp_addr_i = 32'h0000_0203;
        step();
        jmp_i = 1'b0;
        chk("t4_empty", {31'b0, dec_valid}, 32'd0);
        step(8);
        chk("t4_grant3", grants[3], 32'h0000_0200);

        // Reset during an outstanding fetch with stray rvalid
        do_reset();
        rdelay = 3;
        wait_grants(2);
        rstn = 1'b0; mem_auto = 1'b0; man_rvalid = 1'b1; man_rdata = 32'hDEAD_BEEF;
        #1;
        chk("t6_req", {31'b0, imem_req}, 32'd0);
        chk("t6_valid", {31'b0, dec_valid}, 32'd0);
        chk("t6_instr", dec_instr, NOP);
        chk("t6_pc", dec_pc, BOOT);
        step(2);
        grants.delete(); got_pc.delete(); got_instr.delete();
        rstn = 1'b1; mem_auto = 1'b1; man_rvalid = 1'b0;
        step(16);
        chk("t6_grant0", grants[0], BOOT);
        chk("t6_pc0", got_pc[0], 32'h0000_0000);
        chk("t6_instr0", got_instr[0], 32'h0050_0093);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
